execute_muldiv_unit: RTL and testbench
======================================

# execute_muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operation set for the execute stage. It sits beside the single-cycle ALU and accepts an operation when the decoded instruction carries the M-extension encoding. It computes one bit per cycle and raises `busy` so the hazard unit stalls the front of the pipeline. The result is returned on a one-cycle `out_valid` pulse for the EX/MEM register.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; legal values are even and ≥ 8.
- `EARLY_OUT`, 1: when 1, divide-by-zero and signed-overflow cases complete without iterating.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request; high only in IDLE.
- `op` in 3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operand_a` in XLEN: rs1 value, already forwarded.
- `operand_b` in XLEN: rs2 value, already forwarded.
- `flush` in 1: abort the current operation (branch mispredict or jalr).
- `busy` out 1: stall request; high in CALC and FIX.
- `out_valid` out 1: `result` is valid this cycle.
- `result` out XLEN: registered result; holds its value until the next completion.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - On `in_valid && !flush`, latch `op`.
  - Latch the operand magnitudes (absolute value where the operand is signed for `op`) and the result sign.
  - Clear the bit counter and go to CALC.
  - With `EARLY_OUT=1` and a special case, write `result` and go directly to DONE.
- **CALC** (XLEN cycles, counter 0..XLEN-1)
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring step producing one quotient bit per cycle, with an XLEN+1-bit partial remainder.
  - When the counter reaches XLEN-1, go to FIX.
- **FIX** (1 cycle)
  - Apply sign correction: negate the 2·XLEN product if the sign flag is set.
  - Negate the quotient if operand signs differ (DIV only).
  - Give the remainder the dividend's sign (REM only).
  - Select the low or high half, or the quotient or remainder, into `result`.
  - Go to DONE.
- **DONE**: `out_valid = !flush`; go to IDLE on the next edge unconditionally.
- Arithmetic rules:
  - MUL returns the low XLEN bits.
  - MULH is signed×signed high half; MULHSU is signed a × unsigned b high half; MULHU is unsigned high half.
  - DIV and DIVU truncate toward zero.
- Special cases (values are identical whatever `EARLY_OUT` is set to; with `EARLY_OUT=0` they iterate normally and FIX forces these values):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give `operand_a`.
  - Signed overflow (`operand_a` = most-negative, `operand_b` = all ones): DIV gives most-negative; REM gives 0.
- Flush:
  - Any state goes to IDLE on the next edge; `out_valid` is suppressed and `result` is not updated.
  - `flush` together with `in_valid` in IDLE: the request is not accepted.
- Reset (async, `reset_n` low), including mid-operation:
  - State IDLE; `result` 0; `out_valid` 0; `busy` 0.
  - `in_ready` 1 from the first cycle after release.
  - Counter and accumulators are cleared.

## Timing
- Normal request accepted in cycle 0:
  - Cycles 1..XLEN in CALC; cycle XLEN+1 in FIX.
  - Cycle XLEN+2: DONE, `out_valid` high.
  - Cycle XLEN+3: `in_ready` high.
  - Latency is XLEN+2 (34 for XLEN=32).
- Early-out request accepted in cycle 0: `out_valid` in cycle 1, `in_ready` in cycle 2.
- `busy` is high from cycle 1 through cycle XLEN+1. It is low in IDLE and DONE, so the dependent instruction is released in the same cycle `out_valid` is high.
- Back-to-back requests: the minimum spacing between acceptances is XLEN+3 cycles.
- `in_ready` and `out_valid` are decoded from the state register. `out_valid` is also gated combinationally by `flush`; no other outputs depend combinationally on inputs.

## Test plan
Run at XLEN=32 unless stated.
- **Reset:**
  - Hold `reset_n` low, then release → `in_ready`=1, `busy`=0, `out_valid`=0, `result`=0.
  - Assert `reset_n` low in CALC cycle 10 → immediate IDLE; no `out_valid` after release.
- **Multiply:**
  - MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB with `out_valid` in cycle 34.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- **Special cases:**
  - DIVU 0x1234 / 0 → 0xFFFFFFFF; REMU 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - With `EARLY_OUT=1` these give `out_valid` in cycle 1; with `EARLY_OUT=0`, in cycle 34.
- **Flush:**
  - Flush in CALC cycle 5 → IDLE next cycle, no `out_valid`, `result` unchanged.
  - Flush in the DONE cycle → `out_valid` stays 0.
  - Flush with `in_valid` in IDLE → request not accepted.
- **Width and throughput:**
  - XLEN=16: MUL 0x00FF × 0x0101 → 0xFFFF with `out_valid` in cycle 18.
  - Two back-to-back requests with `in_valid` held high → second acceptance exactly XLEN+3 cycles after the first.

Source files
------------

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency XLEN+2 cycles from acceptance to out_valid; 1 cycle for early-out special cases.
// One op in flight: in_ready only in IDLE, busy stalls the pipe in CALC/FIX, flush aborts.
module execute_muldiv_unit #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            busy,
   output logic            out_valid,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   // Multiply: full product. Divide: low half is dividend shifting out / quotient shifting in.
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     rem_q, rem_d;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic                neg_q, neg_d;
   logic                spec_q, spec_d;
   logic [XLEN-1:0]     spec_res_q, spec_res_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_signed, b_signed, a_neg, b_neg, div0, ovf, neg_in;
   logic [XLEN-1:0]     a_mag, b_mag, spec_val;
   logic [XLEN:0]       mul_sum, rem_shift, rem_diff;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

   // Operand conditioning: magnitudes, result sign and special-case detection for the incoming op.
   always_comb begin
      a_signed = (op == 3'd1) || (op == 3'd2) || (op[2] && !op[0]);
      b_signed = (op == 3'd1) || (op[2] && !op[0]);
      a_neg    = a_signed && operand_a[XLEN-1];
      b_neg    = b_signed && operand_b[XLEN-1];
      a_mag    = a_neg ? -operand_a : operand_a;
      b_mag    = b_neg ? -operand_b : operand_b;
      div0     = op[2] && (operand_b == '0);
      ovf      = op[2] && !op[0] && (operand_a == MIN_NEG) && (operand_b == '1);
      spec_val = div0 ? (op[1] ? operand_a : '1) : (op[1] ? '0 : MIN_NEG);
      neg_in   = 1'b0;
      if (op[2]) begin
         // DIV negates on differing signs; REM takes the dividend's sign; unsigned ops never negate.
         if (!op[0]) neg_in = op[1] ? a_neg : (a_neg ^ b_neg);
      end else begin
         neg_in = a_neg ^ b_neg;
      end
   end

   // One iteration step for each datapath, and the sign-corrected final selection.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      rem_shift = {rem_q, acc_q[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, opnd_q};
      prod_fix  = neg_q ? -acc_q : acc_q;
      quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix   = neg_q ? -rem_q : rem_q;
      fix_val   = '0;
      if (spec_q)                fix_val = spec_res_q;
      else if (!op_q[2])         fix_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else                       fix_val = op_q[1] ? rem_fix : quo_fix;
   end

   // Next-state logic: accept, iterate, fix up, present; flush returns to IDLE from anywhere.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      opnd_d     = opnd_q;
      neg_d      = neg_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               op_d       = op;
               cnt_d      = '0;
               rem_d      = '0;
               opnd_d     = op[2] ? b_mag : a_mag;
               acc_d      = {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
               neg_d      = neg_in;
               spec_d     = div0 || ovf;
               spec_res_d = spec_val;
               if (EARLY_OUT && (div0 || ovf)) begin
                  result_d = spec_val;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (!op_q[2]) begin
                  acc_d = {mul_sum, acc_q[XLEN-1:1]};
               end else begin
                  acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], !rem_diff[XLEN]};
                  rem_d = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_val;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Datapath registers; reset clears counter, accumulators and the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q       <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         opnd_q     <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
      end else begin
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         rem_q      <= rem_d;
         opnd_q     <= opnd_d;
         neg_q      <= neg_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
   assign out_valid = (state_q == S_DONE) && !flush;
   assign result    = result_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Bench for execute_muldiv_unit: XLEN=32 with and without early-out, plus XLEN=16.
// Results checked against an arithmetic reference model; latency counted from acceptance.
// Inputs driven just after the rising edge, outputs sampled on the falling edge.
module tb_execute_muldiv_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] opa = '0, opb = '0;
   logic        rdy_eo, busy_eo, ov_eo, rdy_ne, busy_ne, ov_ne;
   logic [31:0] res_eo, res_ne;

   logic        in_valid16 = 1'b0, flush16 = 1'b0;
   logic [2:0]  op16 = 3'd0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        rdy16, busy16, ov16;
   logic [15:0] res16;

   int n_checks = 0;
   int n_pass   = 0;

   execute_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_eo), .op(op),
      .operand_a(opa), .operand_b(opb), .flush(flush), .busy(busy_eo), .out_valid(ov_eo), .result(res_eo));

   execute_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_ne (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_ne), .op(op),
      .operand_a(opa), .operand_b(opb), .flush(flush), .busy(busy_ne), .out_valid(ov_ne), .result(res_ne));

   execute_muldiv_unit #(.XLEN(16), .EARLY_OUT(1'b1)) dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(rdy16), .op(op16),
      .operand_a(a16), .operand_b(b16), .flush(flush16), .busy(busy16), .out_valid(ov16), .result(res16));

   // Reference: RV32M rules evaluated with 64-bit integer arithmetic for width w.
   function automatic logic [31:0] ref_model(input int w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint mask, half, ua, ub, sa, sb, r;
      longint unsigned pu;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua = {32'b0, a} & mask;
      ub = {32'b0, b} & mask;
      sa = (ua ^ half) - half;
      sb = (ub ^ half) - half;
      case (f)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * ub) >>> w;
         3'd3: begin pu = unsigned'(ua) * unsigned'(ub); r = longint'(pu >> w); end
         3'd4: r = (ub == 0) ? -1 : ((sa == -half && sb == -1) ? sa : sa / sb);
         3'd5: r = (ub == 0) ? -1 : ua / ub;
         3'd6: r = (ub == 0) ? sa : ((sa == -half && sb == -1) ? 0 : sa % sb);
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r & mask);
   endfunction

   function automatic bit is_special32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Issue one request to both 32-bit units; report first out_valid cycle, result and busy cycles.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r_eo, output int c_eo, output int bz_eo,
                         output logic [31:0] r_ne, output int c_ne, output int bz_ne);
      int w = 0;
      r_eo = '0; c_eo = 0; bz_eo = 0; r_ne = '0; c_ne = 0; bz_ne = 0;
      @(negedge clk);
      while (!(rdy_eo && rdy_ne) && w < 60) begin @(negedge clk); w++; end
      if (w >= 60) begin n_checks++; $display("FAIL ready_timeout: in_ready eo=%b ne=%b, required 1", rdy_eo, rdy_ne); end
      op = f; opa = a; opb = b; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ov_eo && c_eo == 0) begin c_eo = n; r_eo = res_eo; end
         if (ov_ne && c_ne == 0) begin c_ne = n; r_ne = res_ne; end
         if (busy_eo) bz_eo++;
         if (busy_ne) bz_ne++;
      end
   endtask

   task automatic run16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output int c, output int bz);
      int w = 0;
      r = '0; c = 0; bz = 0;
      @(negedge clk);
      while (!rdy16 && w < 40) begin @(negedge clk); w++; end
      if (w >= 40) begin n_checks++; $display("FAIL ready16_timeout: in_ready=%b, required 1", rdy16); end
      op16 = f; a16 = a; b16 = b; in_valid16 = 1'b1;
      @(posedge clk); #1 in_valid16 = 1'b0;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (ov16 && c == 0) begin c = n; r = res16; end
         if (busy16) bz++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({rdy_eo, busy_eo, ov_eo, res_eo} !== {3'b100, 32'h0}) $display("FAIL reset_eo: rdy/busy/ov/res=%b%b%b %h, required 100 0", rdy_eo, busy_eo, ov_eo, res_eo); else n_pass++;
      n_checks++; if ({rdy_ne, busy_ne, ov_ne, res_ne} !== {3'b100, 32'h0}) $display("FAIL reset_ne: rdy/busy/ov/res=%b%b%b %h, required 100 0", rdy_ne, busy_ne, ov_ne, res_ne); else n_pass++;
      n_checks++; if ({rdy16, busy16, ov16, res16} !== {3'b100, 16'h0}) $display("FAIL reset_16: rdy/busy/ov/res=%b%b%b %h, required 100 0", rdy16, busy16, ov16, res16); else n_pass++;
   endtask

   task automatic test_multiply();
      logic [2:0] tf [4]; logic [31:0] ta [4]; logic [31:0] tb [4]; logic [31:0] te [4];
      logic [31:0] r_eo, r_ne; int c_eo, bz_eo, c_ne, bz_ne;
      tf = '{3'd0, 3'd1, 3'd3, 3'd2};
      ta = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
      te = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) begin
         run_op(tf[i], ta[i], tb[i], r_eo, c_eo, bz_eo, r_ne, c_ne, bz_ne);
         n_checks++; if (r_eo !== te[i]) $display("FAIL mul_res_eo[%0d]: got %h, required %h", i, r_eo, te[i]); else n_pass++;
         n_checks++; if (r_ne !== te[i]) $display("FAIL mul_res_ne[%0d]: got %h, required %h", i, r_ne, te[i]); else n_pass++;
         n_checks++; if (c_eo !== 34) $display("FAIL mul_lat_eo[%0d]: got cycle %0d, required 34", i, c_eo); else n_pass++;
         n_checks++; if (c_ne !== 34) $display("FAIL mul_lat_ne[%0d]: got cycle %0d, required 34", i, c_ne); else n_pass++;
         n_checks++; if (bz_ne !== 33) $display("FAIL mul_busy_ne[%0d]: got %0d busy cycles, required 33", i, bz_ne); else n_pass++;
      end
   endtask

   task automatic test_divide();
      logic [2:0] tf [4]; logic [31:0] ta [4]; logic [31:0] tb [4]; logic [31:0] te [4];
      logic [31:0] r_eo, r_ne; int c_eo, bz_eo, c_ne, bz_ne;
      tf = '{3'd4, 3'd6, 3'd5, 3'd7};
      ta = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      tb = '{32'd2, 32'd2, 32'd7, 32'd7};
      te = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         run_op(tf[i], ta[i], tb[i], r_eo, c_eo, bz_eo, r_ne, c_ne, bz_ne);
         n_checks++; if (r_eo !== te[i]) $display("FAIL div_res_eo[%0d]: got %h, required %h", i, r_eo, te[i]); else n_pass++;
         n_checks++; if (r_ne !== te[i]) $display("FAIL div_res_ne[%0d]: got %h, required %h", i, r_ne, te[i]); else n_pass++;
         n_checks++; if (c_ne !== 34) $display("FAIL div_lat_ne[%0d]: got cycle %0d, required 34", i, c_ne); else n_pass++;
         n_checks++; if (bz_eo !== 33) $display("FAIL div_busy_eo[%0d]: got %0d busy cycles, required 33", i, bz_eo); else n_pass++;
      end
   endtask

   task automatic test_special();
      logic [2:0] tf [4]; logic [31:0] ta [4]; logic [31:0] tb [4]; logic [31:0] te [4];
      logic [31:0] r_eo, r_ne; int c_eo, bz_eo, c_ne, bz_ne;
      tf = '{3'd5, 3'd7, 3'd4, 3'd6};
      ta = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
      tb = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      te = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};
      for (int i = 0; i < 4; i++) begin
         run_op(tf[i], ta[i], tb[i], r_eo, c_eo, bz_eo, r_ne, c_ne, bz_ne);
         n_checks++; if (r_eo !== te[i]) $display("FAIL spec_res_eo[%0d]: got %h, required %h", i, r_eo, te[i]); else n_pass++;
         n_checks++; if (r_ne !== te[i]) $display("FAIL spec_res_ne[%0d]: got %h, required %h", i, r_ne, te[i]); else n_pass++;
         n_checks++; if (c_eo !== 1) $display("FAIL spec_lat_eo[%0d]: got cycle %0d, required 1", i, c_eo); else n_pass++;
         n_checks++; if (c_ne !== 34) $display("FAIL spec_lat_ne[%0d]: got cycle %0d, required 34", i, c_ne); else n_pass++;
         n_checks++; if (bz_eo !== 0) $display("FAIL spec_busy_eo[%0d]: got %0d busy cycles, required 0", i, bz_eo); else n_pass++;
      end
   endtask

   task automatic test_reset_midop();
      int pulses = 0;
      @(negedge clk);
      op = 3'd0; opa = 32'd3; opb = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if ({rdy_ne, busy_ne, ov_ne, res_ne} !== {3'b100, 32'h0}) $display("FAIL midreset_ne: rdy/busy/ov/res=%b%b%b %h, required 100 0", rdy_ne, busy_ne, ov_ne, res_ne); else n_pass++;
      n_checks++; if ({busy_eo, ov_eo, res_eo} !== {2'b00, 32'h0}) $display("FAIL midreset_eo: busy/ov/res=%b%b %h, required 00 0", busy_eo, ov_eo, res_eo); else n_pass++;
      @(negedge clk) reset_n = 1'b1;
      for (int n = 0; n < 40; n++) begin @(negedge clk); if (ov_ne || ov_eo) pulses++; end
      n_checks++; if (pulses !== 0) $display("FAIL midreset_no_valid: got %0d out_valid cycles, required 0", pulses); else n_pass++;
   endtask

   task automatic test_flush();
      int pulses = 0;
      logic [31:0] prev;
      prev = res_ne;
      // Flush during CALC cycle 5.
      @(negedge clk);
      op = 3'd0; opa = 32'd6; opb = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      n_checks++; if ({rdy_ne, busy_ne} !== 2'b10) $display("FAIL flush_calc_idle: rdy/busy=%b%b, required 10", rdy_ne, busy_ne); else n_pass++;
      for (int n = 0; n < 40; n++) begin @(negedge clk); if (ov_ne || ov_eo) pulses++; end
      n_checks++; if (pulses !== 0) $display("FAIL flush_calc_valid: got %0d out_valid cycles, required 0", pulses); else n_pass++;
      n_checks++; if (res_ne !== prev) $display("FAIL flush_calc_result: got %h, required %h", res_ne, prev); else n_pass++;
      // Flush in the DONE cycle.
      @(negedge clk);
      op = 3'd0; opa = 32'd6; opb = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (33) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      n_checks++; if ({rdy_ne, busy_ne, ov_ne} !== 3'b000) $display("FAIL flush_done_valid: rdy/busy/ov=%b%b%b, required 000", rdy_ne, busy_ne, ov_ne); else n_pass++;
      n_checks++; if (res_ne !== 32'd42) $display("FAIL flush_done_result: got %h, required %h", res_ne, 32'd42); else n_pass++;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      n_checks++; if (rdy_ne !== 1'b1 || ov_ne !== 1'b0) $display("FAIL flush_done_idle: rdy/ov=%b%b, required 10", rdy_ne, ov_ne); else n_pass++;
      // Flush together with a request in IDLE.
      pulses = 0;
      @(negedge clk);
      op = 3'd0; opa = 32'd2; opb = 32'd2; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_checks++; if ({rdy_ne, busy_ne, rdy_eo, busy_eo} !== 4'b1010) $display("FAIL flush_idle_reject: rdy/busy ne=%b%b eo=%b%b, required 10 10", rdy_ne, busy_ne, rdy_eo, busy_eo); else n_pass++;
      for (int n = 0; n < 40; n++) begin @(negedge clk); if (ov_ne || ov_eo) pulses++; end
      n_checks++; if (pulses !== 0 || res_ne !== 32'd42) $display("FAIL flush_idle_nores: pulses %0d res %h, required 0 and %h", pulses, res_ne, 32'd42); else n_pass++;
   endtask

   task automatic test_width16();
      logic [15:0] r, a, b; logic [31:0] e; logic [2:0] f; int c, bz; bit sp;
      run16(3'd0, 16'h00FF, 16'h0101, r, c, bz);
      n_checks++; if (r !== 16'hFFFF) $display("FAIL w16_mul_res: got %h, required ffff", r); else n_pass++;
      n_checks++; if (c !== 18) $display("FAIL w16_mul_lat: got cycle %0d, required 18", c); else n_pass++;
      n_checks++; if (bz !== 17) $display("FAIL w16_busy: got %0d busy cycles, required 17", bz); else n_pass++;
      for (int i = 0; i < 12; i++) begin
         f = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom);
         if (i % 4 == 1) b = 16'h0;
         if (i % 4 == 2) begin a = 16'h8000; b = 16'hFFFF; end
         sp = f[2] && (b == 16'h0 || (!f[0] && a == 16'h8000 && b == 16'hFFFF));
         e = ref_model(16, f, {16'h0, a}, {16'h0, b});
         run16(f, a, b, r, c, bz);
         n_checks++; if (r !== e[15:0]) $display("FAIL w16_rand_res op%0d %h,%h: got %h, required %h", f, a, b, r, e[15:0]); else n_pass++;
         n_checks++; if (c !== (sp ? 1 : 18)) $display("FAIL w16_rand_lat op%0d: got cycle %0d, required %0d", f, c, sp ? 1 : 18); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int first_ne = -1, second_ne = -1, first_eo = -1, second_eo = -1;
      logic s_ne, s_eo;
      @(negedge clk);
      op = 3'd0; opa = 32'd5; opb = 32'd9; in_valid = 1'b1;
      for (int t = 0; t < 150 && (second_ne < 0 || second_eo < 0); t++) begin
         s_ne = rdy_ne; s_eo = rdy_eo;
         @(posedge clk);
         if (s_ne) begin if (first_ne < 0) first_ne = t; else if (second_ne < 0) second_ne = t; end
         if (s_eo) begin if (first_eo < 0) first_eo = t; else if (second_eo < 0) second_eo = t; end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if (second_ne - first_ne !== 35 || second_ne < 0) $display("FAIL b2b_spacing_ne: got %0d, required 35", second_ne - first_ne); else n_pass++;
      n_checks++; if (second_eo - first_eo !== 35 || second_eo < 0) $display("FAIL b2b_spacing_eo: got %0d, required 35", second_eo - first_eo); else n_pass++;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] a, b, e, r_eo, r_ne; logic [2:0] f; int c_eo, bz_eo, c_ne, bz_ne; bit sp;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         e  = ref_model(32, f, a, b);
         sp = is_special32(f, a, b);
         run_op(f, a, b, r_eo, c_eo, bz_eo, r_ne, c_ne, bz_ne);
         n_checks++; if (r_eo !== e) $display("FAIL rand_res_eo op%0d %h,%h: got %h, required %h", f, a, b, r_eo, e); else n_pass++;
         n_checks++; if (r_ne !== e) $display("FAIL rand_res_ne op%0d %h,%h: got %h, required %h", f, a, b, r_ne, e); else n_pass++;
         n_checks++; if (c_eo !== (sp ? 1 : 34)) $display("FAIL rand_lat_eo op%0d: got cycle %0d, required %0d", f, c_eo, sp ? 1 : 34); else n_pass++;
         n_checks++; if (c_ne !== 34) $display("FAIL rand_lat_ne op%0d: got cycle %0d, required 34", f, c_ne); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_special();
      test_reset_midop();
      test_flush();
      test_width16();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
